// File: rtl/gray_count16_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray-code counter.
// The FIFO pointer logic and the benches reuse these.
//   GRAY_W    : default counter width in bits
//   bin2gray  : binary -> Gray, g = b ^ (b >> 1)
//   gray2bin  : Gray -> binary, prefix XOR running from the MSB down
package gray_count16_pkg;

    localparam int unsigned GRAY_W = 16;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_count16_if.sv
// Output bundle of the Gray-code counter.
//   gray   : current Gray code, WIDTH bits, always driven straight from a flop
// Modports:
//   master : the counter, which drives gray
//   slave  : a consumer, which samples gray (possibly from another clock domain)
interface gray_count16_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] gray;

    modport master (output gray);
    modport slave  (input  gray);
endinterface

// File: rtl/gray_count16_bin2gray.sv
// Purely combinational binary-to-Gray converter.
//   bin  : binary input, WIDTH bits
//   gray : Gray-coded output, gray = bin ^ (bin >> 1)
module gray_count16_bin2gray #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_count16.sv
// Free-running Gray-code counter. Advances one code per rising clock edge and has
// no enable and no load input. Successive outputs differ in exactly one bit, so a
// consumer in another clock domain can sample the value safely.
//   clk  : clock; all state updates on the rising edge
//   rstn : asynchronous active-low reset; clears every flop
//   cnt  : master modport; cnt.gray is the registered Gray code
module gray_count16
    import gray_count16_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W
) (
    input  logic           clk,
    input  logic           rstn,
    gray_count16_if.master cnt
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // Convert the next binary value rather than the current one. That way the
    // binary and Gray registers load on the same edge, and gray stays a bare
    // flop output with no logic after it.
    assign bin_d = bin_q + WIDTH'(1);

    gray_count16_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (bin_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign cnt.gray = gray_q;

`ifdef GRAY_COUNT16_ASSERTS
    // Exactly one bit flips on every edge that follows a cycle spent out of reset.
    a_one_bit_step : assert property (
        @(posedge clk) disable iff (!rstn)
        $past(rstn) |-> ($countones(gray_q ^ $past(gray_q)) == 1)
    );

    // The Gray and binary registers must always describe the same count.
    if (WIDTH == GRAY_W) begin : g_track
        a_gray_tracks_bin : assert property (
            @(posedge clk) disable iff (!rstn)
            gray2bin(gray_q) == bin_q
        );
    end
`endif

endmodule

// File: tb/tb_gray_count16.sv
// Self-checking bench for gray_count16. The reference model keeps a plain integer
// count of the edges seen since reset release. The expected code is derived from
// that count with arithmetic.
module tb_gray_count16;
    import gray_count16_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    gray_count16_if #(.WIDTH(GRAY_W)) cnt_if ();

    gray_count16 #(
        .WIDTH (GRAY_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .cnt  (cnt_if.master)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int unsigned edges     = 0;  // model: edges counted since reset release

    function automatic logic [15:0] model_gray(input int unsigned n);
        int unsigned m;
        m = n % 65536;
        return 16'(m ^ (m / 2));
    endfunction

    // One rising edge. The model advances only if reset was released before it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rstn) edges++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn  = 1'b1;
        edges = 0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        total_cnt++;
        if (cnt_if.gray !== 16'h0000)
            $display("FAIL reset_async: got %h expected 0000", cnt_if.gray);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (cnt_if.gray !== 16'h0000)
                $display("FAIL reset_hold[%0d]: got %h expected 0000", i, cnt_if.gray);
            else pass_cnt++;
        end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_seq [8];
        exp_seq = '{16'h0001, 16'h0003, 16'h0002, 16'h0006,
                    16'h0007, 16'h0005, 16'h0004, 16'h000C};
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if (cnt_if.gray !== exp_seq[i])
                $display("FAIL sequence[%0d]: got %h expected %h", i, cnt_if.gray, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_walk();
        logic [15:0] prev;
        int unsigned n;
        n = 50 + $urandom_range(0, 20);
        prev = cnt_if.gray;
        for (int i = 0; i < int'(n); i++) begin
            tick();
            total_cnt++;
            if ($countones(prev ^ cnt_if.gray) != 1)
                $display("FAIL walk_onebit: got %h after %h expected one-bit change",
                         cnt_if.gray, prev);
            else pass_cnt++;
            total_cnt++;
            if (gray2bin(cnt_if.gray) !== edges[15:0])
                $display("FAIL walk_count: got %h expected %h",
                         gray2bin(cnt_if.gray), edges[15:0]);
            else pass_cnt++;
            total_cnt++;
            if (cnt_if.gray !== model_gray(edges))
                $display("FAIL walk_code: got %h expected %h", cnt_if.gray, model_gray(edges));
            else pass_cnt++;
            prev = cnt_if.gray;
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rstn = 1'b0;
        release_reset();
        for (int i = 0; i < 65535; i++) tick();
        total_cnt++;
        if (cnt_if.gray !== 16'h8000)
            $display("FAIL wrap_top: got %h expected 8000", cnt_if.gray);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cnt_if.gray !== 16'h0000 || cnt_if.gray !== model_gray(edges))
            $display("FAIL wrap_zero: got %h expected 0000", cnt_if.gray);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cnt_if.gray !== 16'h0001)
            $display("FAIL wrap_resume: got %h expected 0001", cnt_if.gray);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 20; i++) tick();
        total_cnt++;
        if (cnt_if.gray !== model_gray(edges))
            $display("FAIL async_pre: got %h expected %h", cnt_if.gray, model_gray(edges));
        else pass_cnt++;
        @(posedge clk);
        #($urandom_range(1, 3));
        rstn = 1'b0;
        #1;  // still well before the next rising edge
        total_cnt++;
        if (cnt_if.gray !== 16'h0000)
            $display("FAIL async_clear: got %h expected 0000", cnt_if.gray);
        else pass_cnt++;
        release_reset();
        tick();
        total_cnt++;
        if (cnt_if.gray !== 16'h0001)
            $display("FAIL async_restart: got %h expected 0001", cnt_if.gray);
        else pass_cnt++;
    endtask

    task automatic test_reset_held();
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (cnt_if.gray !== 16'h0000)
                $display("FAIL held[%0d]: got %h expected 0000", i, cnt_if.gray);
            else pass_cnt++;
        end
        release_reset();
        tick();
        total_cnt++;
        if (cnt_if.gray !== 16'h0001)
            $display("FAIL held_restart: got %h expected 0001", cnt_if.gray);
        else pass_cnt++;
    endtask

    task automatic test_random_resets();
        for (int r = 0; r < 4; r++) begin
            int unsigned run;
            run = $urandom_range(1, 30);
            for (int i = 0; i < int'(run); i++) begin
                tick();
                total_cnt++;
                if (cnt_if.gray !== model_gray(edges))
                    $display("FAIL rand[%0d]: got %h expected %h",
                             r, cnt_if.gray, model_gray(edges));
                else pass_cnt++;
            end
            @(posedge clk);
            #($urandom_range(1, 3));
            rstn = 1'b0;
            #1;
            total_cnt++;
            if (cnt_if.gray !== 16'h0000)
                $display("FAIL rand_clear[%0d]: got %h expected 0000", r, cnt_if.gray);
            else pass_cnt++;
            release_reset();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_walk();
        test_async_reset();
        test_reset_held();
        test_random_resets();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
